// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: one load/store per request, fixed-latency
// SRAM model, byte/half/word lanes with sign/zero-extended loads. The core is
// stalled from request acceptance until the single-cycle done pulse.
module dmem_ctrl #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic            legal, accept, commit;

  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [3:0]      lane_mask;
  logic [31:0]     lane_wdata;
  logic [31:0]     mem_word, shifted, load_val;

  // Only the word index and lane bits matter; upper address bits wrap away.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  // Decode legality of the incoming request: funct3 and natural alignment.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~req_addr[0];
      3'b010:  legal = (req_addr[1:0] == 2'b00);
      3'b100:  legal = ~req_we;
      3'b101:  legal = ~req_we & ~req_addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Next-state and handshake outputs; stall/err are combinational in IDLE.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            accept    = 1'b1;
            stall     = 1'b1;
            state_nxt = BUSY;
          end else begin
            err = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, wait counter and latched request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= CW'(LATENCY - 1);
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        we_q    <= req_we;
        f3_q    <= req_funct3;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign idx  = addr_q[AW+1:2];
  assign lane = addr_q[1:0];

  // Store lane enables and store data replicated onto every candidate lane.
  always_comb begin
    lane_mask  = 4'b1111;
    lane_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        lane_mask  = 4'b0001 << lane;
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask  = lane[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  assign mem_word = mem[idx];
  assign shifted  = mem_word >> {lane, 3'b000};

  // Load extraction and sign/zero extension.
  always_comb begin
    load_val = mem_word;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = mem_word;
    endcase
  end

  // Storage array is intentionally not reset; commit is gated by the reset state.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

  // Load result register: updated only when a load commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (commit && !we_q) begin
      rdata <= load_val;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: scoreboard queue of expected rdata per access,
// compared when done pulses; latency, err, reset-abort and wrap-around checks.
module tb_dmem_ctrl;

  localparam int unsigned LAT = 2;

  logic        clk, reset, req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        stall, done, err;
  logic [31:0] rdata;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_rdata;
  time         last_done;

  dmem_ctrl #(.DEPTH(64), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One legal access; exp is the load result (ignored for stores).
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp);
    int  cyc;
    bit  seen;
    logic [31:0] want;
    @(negedge clk);
    if (!we) exp_rdata = exp;
    sb_q.push_back(exp_rdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    check($sformatf("%s/stall_accept", tag), stall, 1);
    check($sformatf("%s/err_accept", tag), err, 0);
    cyc  = 1;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
      else check($sformatf("%s/stall_busy", tag), stall, 1);
    end
    req_valid = 1'b0;
    want = sb_q.pop_front();
    if (!seen) begin
      check($sformatf("%s/timeout", tag), done, 1);
    end else begin
      last_done = $time;
      check($sformatf("%s/latency", tag), 32'(cyc), 32'(LAT + 2));
      check($sformatf("%s/stall_resp", tag), stall, 0);
      check($sformatf("%s/rdata", tag), rdata, want);
    end
  endtask

  // Illegal request held for a few cycles: err only, never stall or done.
  task automatic bad_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = 32'hFFFF_FFFF;
    #1;
    check($sformatf("%s/err", tag), err, 1);
    check($sformatf("%s/stall", tag), stall, 0);
    check($sformatf("%s/done", tag), done, 0);
    repeat (2) begin
      @(negedge clk);
      check($sformatf("%s/err_hold", tag), err, 1);
      check($sformatf("%s/stall_hold", tag), stall, 0);
      check($sformatf("%s/done_hold", tag), done, 0);
    end
    req_valid = 1'b0;
    #1;
    check($sformatf("%s/err_clear", tag), err, 0);
    check($sformatf("%s/rdata_kept", tag), rdata, exp_rdata);
  endtask

  initial begin
    time t1;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    exp_rdata  = '0;
    last_done  = 0;
    #1;
    check("reset/stall", stall, 0);
    check("reset/done", done, 0);
    check("reset/err", err, 0);
    check("reset/rdata", rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic word store/load
    access("sw100", 1, 3'b010, 32'd100, 32'd25, 0);
    access("lw100", 0, 3'b010, 32'd100, 0, 32'h0000_0019);

    // Byte lanes
    access("sw40", 1, 3'b010, 32'h40, 32'h1122_3344, 0);
    access("sb41", 1, 3'b000, 32'h41, 32'h0000_00AB, 0);
    access("lw40a", 0, 3'b010, 32'h40, 0, 32'h1122_AB44);
    access("lbu41", 0, 3'b100, 32'h41, 0, 32'h0000_00AB);
    access("lb41", 0, 3'b000, 32'h41, 0, 32'hFFFF_FFAB);

    // Half-word lanes
    access("sh42", 1, 3'b001, 32'h42, 32'h0000_8001, 0);
    access("lh42", 0, 3'b001, 32'h42, 0, 32'hFFFF_8001);
    access("lhu42", 0, 3'b101, 32'h42, 0, 32'h0000_8001);
    access("lw40b", 0, 3'b010, 32'h40, 0, 32'h8001_AB44);
    access("lb43", 0, 3'b000, 32'h43, 0, 32'hFFFF_FF80);
    access("lbu40", 0, 3'b100, 32'h40, 0, 32'h0000_0044);
    access("lh40", 0, 3'b001, 32'h40, 0, 32'hFFFF_AB44);

    // Illegal accesses leave memory and rdata alone
    bad_access("lw42_mis", 0, 3'b010, 32'h42);
    bad_access("sh43_mis", 1, 3'b001, 32'h43);
    bad_access("ld_f3_011", 0, 3'b011, 32'h40);
    bad_access("st_f3_100", 1, 3'b100, 32'h40);
    access("lw40c", 0, 3'b010, 32'h40, 0, 32'h8001_AB44);

    // Reset during the second BUSY cycle aborts the store
    access("sw10", 1, 3'b010, 32'h10, 32'h0BAD_F00D, 0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    exp_rdata = '0;
    check("abort/stall", stall, 0);
    check("abort/done", done, 0);
    check("abort/err", err, 0);
    check("abort/rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    access("lw10", 0, 3'b010, 32'h10, 0, 32'h0BAD_F00D);

    // Address wrap modulo 4*DEPTH, top word
    access("sw104", 1, 3'b010, 32'h104, 32'd7, 0);
    access("lw004", 0, 3'b010, 32'h004, 0, 32'd7);
    access("swFC", 1, 3'b010, 32'hFC, 32'hCAFE_BABE, 0);
    access("lw1FC", 0, 3'b010, 32'h1FC, 0, 32'hCAFE_BABE);

    // Back-to-back loads: second accepted the cycle after the first RESP
    access("b2b_1", 0, 3'b010, 32'h004, 0, 32'd7);
    t1 = last_done;
    access("b2b_2", 0, 3'b010, 32'h40, 0, 32'h8001_AB44);
    check("b2b/spacing", 32'(last_done - t1), 32'((LAT + 2) * 10));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
